// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm zone controller: FSM states,
// the 0xBA-family state codes reported over SPI, and the countdown width.
package alarm_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ST_DISARMED    = 3'd0,
    ST_EXIT_DELAY  = 3'd1,
    ST_ARMED       = 3'd2,
    ST_ENTRY_DELAY = 3'd3,
    ST_ALARM       = 3'd4
  } alarm_state_e;

  localparam logic [7:0] CODE_DISARMED    = 8'hBA;
  localparam logic [7:0] CODE_ARMED       = 8'hBB;
  localparam logic [7:0] CODE_ENTRY_DELAY = 8'hBC;
  localparam logic [7:0] CODE_ALARM       = 8'hBD;
  localparam logic [7:0] CODE_EXIT_DELAY  = 8'hBE;

  function automatic logic [7:0] state_to_code(input alarm_state_e s);
    logic [7:0] code;
    case (s)
      ST_EXIT_DELAY:  code = CODE_EXIT_DELAY;
      ST_ARMED:       code = CODE_ARMED;
      ST_ENTRY_DELAY: code = CODE_ENTRY_DELAY;
      ST_ALARM:       code = CODE_ALARM;
      default:        code = CODE_DISARMED;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/alarm_zone_controller_if.sv
// Control/status bundle between the authentication/sensor side and the
// alarm controller; state_dbg mirrors the FSM state for checkers.
interface alarm_zone_controller_if #(
  parameter int NUM_ZONES = 4
) ();
  import alarm_pkg::*;

  // arm_req and auth_ok are single-cycle pulses with no back-pressure: the
  // controller acts on them in the cycle they are high or ignores them.
  logic                 arm_req;
  logic                 auth_ok;
  logic [NUM_ZONES-1:0] zone_in;
  logic [NUM_ZONES-1:0] zone_mask;
  logic [NUM_ZONES-1:0] instant_mask;
  logic [7:0]           state_code;
  logic                 engaged;
  logic                 buzzer;
  logic [CNT_W-1:0]     countdown;
  logic [NUM_ZONES-1:0] tripped;
  alarm_state_e         state_dbg;

  modport master (
    output arm_req, auth_ok, zone_in, zone_mask, instant_mask,
    input  state_code, engaged, buzzer, countdown, tripped, state_dbg
  );

  modport slave (
    input  arm_req, auth_ok, zone_in, zone_mask, instant_mask,
    output state_code, engaged, buzzer, countdown, tripped, state_dbg
  );

endinterface

// File: rtl/alarm_zone_controller_sec_tick_gen.sv
// One-second pulse generator; clear restarts the second so each timed
// state gets a full first second.
module sec_tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] tick_cnt_q;
  logic [W-1:0] tick_cnt_d;

  always_comb begin
    tick_cnt_d = tick_cnt_q + 1'b1;
    if (clear || tick_cnt_q == LAST) begin
      tick_cnt_d = '0;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign tick = (tick_cnt_q == LAST);

endmodule

// File: rtl/alarm_zone_controller.sv
// Multi-zone alarm controller: exit delay, entry delay, alarm timeout and a
// sticky record of the zones that tripped.
module alarm_zone_controller
  import alarm_pkg::*;
#(
  parameter int NUM_ZONES       = 4,
  parameter int TICK_DIV        = 50000000,
  parameter int EXIT_DELAY_S    = 30,
  parameter int ENTRY_DELAY_S   = 60,
  parameter int ALARM_TIMEOUT_S = 180
) (
  input logic                     CLOCK_50,
  input logic                     reset,
  alarm_zone_controller_if.slave  bus
);

  localparam logic [CNT_W-1:0] EXIT_LOAD    = CNT_W'(EXIT_DELAY_S);
  localparam logic [CNT_W-1:0] ENTRY_LOAD   = CNT_W'(ENTRY_DELAY_S);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(ALARM_TIMEOUT_S);

  logic [NUM_ZONES-1:0] sync1_q, sync2_q;
  logic [NUM_ZONES-1:0] tripped_q, tripped_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  alarm_state_e         state_q, state_d;

  logic [NUM_ZONES-1:0] active;
  logic                 instant_hit;
  logic                 sec_tick;
  logic                 tick_clear;

  assign active      = sync2_q & bus.zone_mask;
  assign instant_hit = |(active & bus.instant_mask);
  assign tick_clear  = (state_d != state_q);

  sec_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .clear    (tick_clear),
    .tick     (sec_tick)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tripped_d = tripped_q;
    case (state_q)
      ST_DISARMED: begin
        if (bus.arm_req) begin
          tripped_d = '0;
          if (EXIT_DELAY_S == 0) begin
            state_d = ST_ARMED;
            cnt_d   = '0;
          end else begin
            state_d = ST_EXIT_DELAY;
            cnt_d   = EXIT_LOAD;
          end
        end
      end
      ST_EXIT_DELAY: begin
        if (bus.auth_ok) begin
          state_d = ST_DISARMED;
          cnt_d   = '0;
        end else if (sec_tick) begin
          if (cnt_q <= 8'd1) begin
            state_d = ST_ARMED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      ST_ARMED: begin
        if (bus.auth_ok) begin
          state_d = ST_DISARMED;
        end else if (instant_hit) begin
          state_d   = ST_ALARM;
          cnt_d     = TIMEOUT_LOAD;
          tripped_d = tripped_q | active;
        end else if (|active) begin
          state_d   = ST_ENTRY_DELAY;
          cnt_d     = ENTRY_LOAD;
          tripped_d = tripped_q | active;
        end
      end
      ST_ENTRY_DELAY: begin
        tripped_d = tripped_q | active;
        if (bus.auth_ok) begin
          state_d = ST_DISARMED;
          cnt_d   = '0;
        end else if (instant_hit || (sec_tick && cnt_q <= 8'd1)) begin
          state_d = ST_ALARM;
          cnt_d   = TIMEOUT_LOAD;
        end else if (sec_tick) begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_ALARM: begin
        tripped_d = tripped_q | active;
        if (bus.auth_ok) begin
          state_d = ST_DISARMED;
          cnt_d   = '0;
        end else if (ALARM_TIMEOUT_S != 0 && sec_tick) begin
          // Timing out re-arms rather than disarms; tripped stays for review.
          if (cnt_q <= 8'd1) begin
            state_d = ST_ARMED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: begin
        state_d = ST_DISARMED;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      state_q   <= ST_DISARMED;
      cnt_q     <= '0;
      tripped_q <= '0;
    end else begin
      sync1_q   <= bus.zone_in;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tripped_q <= tripped_d;
    end
  end

  assign bus.state_code = state_to_code(state_q);
  assign bus.engaged    = (state_q != ST_DISARMED);
  assign bus.buzzer     = (state_q == ST_ALARM);
  assign bus.countdown  = cnt_q;
  assign bus.tripped    = tripped_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: doc/alarm_zone_controller.md
Name: alarm_zone_controller

Overview:
- Parametrised successor of the single-sensor engage/countdown/alert state machine.
- Supervises NUM_ZONES debounced motion/contact inputs with per-zone enable and instant-alarm masks.
- Adds an exit delay, an entry delay, and an alarm auto-timeout, and latches the zones that tripped.
- Sits between the UID authentication logic (auth_ok pulse) and the SPI command/LED/buzzer/HEX outputs; state_code feeds the existing 0xBA-family SPI state command.

Parameters:
- NUM_ZONES, 4: number of sensor inputs (1..16).
- TICK_DIV, 50000000: CLOCK_50 cycles per countdown second (>=2).
- EXIT_DELAY_S, 30: seconds from arm request to armed (0..255); 0 means arm immediately.
- ENTRY_DELAY_S, 60: seconds from non-instant zone trip to alarm (1..255).
- ALARM_TIMEOUT_S, 180: seconds the buzzer sounds before re-arming (0..255); 0 means sound until authenticated.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- arm_req  in  1  single-cycle pulse requesting engage.
- auth_ok  in  1  single-cycle pulse from UID check on a valid card.
- zone_in  in  NUM_ZONES  raw asynchronous sensor levels, 1 = motion/open.
- zone_mask  in  NUM_ZONES  1 = zone enabled; quasi-static.
- instant_mask  in  NUM_ZONES  1 = zone bypasses entry delay.
- state_code  out  8  0xBA disarmed, 0xBB armed, 0xBC entry delay, 0xBD alarm, 0xBE exit delay.
- engaged  out  1  high in every state except DISARMED.
- buzzer  out  1  high only in ALARM.
- countdown  out  8  seconds remaining in the current timed state, else 0.
- tripped  out  NUM_ZONES  sticky record of zones that caused or joined an event.

Behaviour:
- Reset: state DISARMED, state_code 0xBA, engaged 0, buzzer 0, countdown 0, tripped 0, synchronisers and tick counter 0.
- zone_in passes through a 2-flop synchroniser. active = sync & zone_mask. Sensor-to-decision latency is 2 cycles; outputs are registered and change 1 cycle after the decision cycle.
- Tick: tick_cnt counts 0..TICK_DIV-1 and pulses sec_tick on the TICK_DIV-1 cycle. tick_cnt clears on every state entry, so the first second of each timed state lasts exactly TICK_DIV cycles.
- Priority in every cycle: reset > auth_ok > zone events > sec_tick.
- DISARMED:
  - arm_req clears tripped, loads countdown=EXIT_DELAY_S and enters EXIT_DELAY; if EXIT_DELAY_S==0, enters ARMED directly.
  - auth_ok and zone activity are ignored.
- EXIT_DELAY (0xBE):
  - zones ignored.
  - auth_ok -> DISARMED.
  - On sec_tick: if countdown==1, countdown<=0 and enter ARMED; else decrement.
- ARMED (0xBB):
  - auth_ok -> DISARMED.
  - Else if (active & instant_mask)!=0 -> ALARM.
  - Else if active!=0 -> ENTRY_DELAY with countdown=ENTRY_DELAY_S.
  - tripped |= active on the transition.
- ENTRY_DELAY (0xBC):
  - tripped |= active every cycle.
  - auth_ok -> DISARMED, with tripped retained.
  - An instant zone going active -> ALARM immediately.
  - sec_tick at countdown==1 -> ALARM.
- ALARM (0xBD):
  - buzzer=1; countdown=ALARM_TIMEOUT_S on entry; tripped |= active every cycle.
  - auth_ok -> DISARMED.
  - If ALARM_TIMEOUT_S!=0: sec_tick at countdown==1 -> ARMED with buzzer 0 and tripped retained. A zone still active then follows the ARMED rules on the next cycle.
  - If ALARM_TIMEOUT_S==0: countdown stays 0 and the state holds until auth_ok.
- arm_req outside DISARMED is ignored; auth_ok inside DISARMED is ignored.
- auth_ok and a zone trip in the same cycle: auth wins, go to DISARMED.
- countdown never underflows; it reads 0 in DISARMED and ARMED.
- Asynchronous reset mid-countdown aborts immediately to reset values; no partial state survives.

Decomposition:
- Shared package alarm_pkg:
  - state enum (DISARMED, EXIT_DELAY, ARMED, ENTRY_DELAY, ALARM).
  - 8-bit state-code constants 0xBA..0xBE.
  - CNT_W=8.
- Sub-module sec_tick_gen (TICK_DIV; CLOCK_50, reset, clear, tick) supplies the one-second pulse. The synchroniser and FSM stay in the top.

Test Plan (NUM_ZONES=4, TICK_DIV=4, EXIT=3, ENTRY=5, TIMEOUT=2):
- Arm: arm_req pulse -> 0xBE, countdown 3,2,1 every 4 cycles, then 0xBB after 12 cycles with countdown 0; zone_in=4'b0001 during exit -> no change.
- Entry: armed, zone_in=4'b0010, mask=4'hF, instant=0 -> 0xBC 3 cycles later with countdown 5 and tripped=4'b0010; no auth -> 0xBD after 20 cycles with buzzer 1.
- Disarm during entry: auth_ok at countdown 3 -> 0xBA next cycle, buzzer 0, engaged 0, tripped still 4'b0010.
- Instant/mask: instant_mask=4'b1000, zone 3 high -> 0xBD directly; zone_mask=4'b0111 with zone 3 high -> stays 0xBB.
- Timeout/simultaneous: alarm holds 8 cycles then 0xBB, buzzer 0; auth_ok in the same cycle as a zone trip in ARMED -> 0xBA.
- Reset: assert reset mid-ALARM -> all outputs at reset values asynchronously, 0xBA.
